// File: rtl/mem_channel_arbiter.sv
// Arbitrates NUM_CH requesters onto one registered memory port (round-robin or fixed priority).
// Grant is registered one cycle after the request; ch_acknowledge follows mem_acknowledge by one cycle, with a timeout fallback.
module mem_channel_arbiter #(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 128,
  parameter  int ADDR_W      = 26,
  parameter  int ARB_MODE    = 0,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
  output logic [NUM_CH-1:0]        ch_acknowledge,
  output logic [NUM_CH-1:0]        ch_error,
  output logic [DATA_W-1:0]        ch_read_data,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [BE_W-1:0]          mem_byte_enable,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_write_data,
  input  logic                     mem_acknowledge,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [15:0]              txn_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int PW = $clog2(NUM_CH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            state, state_nx;
  logic [PW-1:0]     rr_ptr, base, idx, win;
  logic [TW-1:0]     tmo_cnt;
  logic              err, tmo_hit, any_pend, sel_wr;
  logic [NUM_CH-1:0] pend;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  assign pend     = ch_read | ch_write;
  assign any_pend = |pend;
  assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Scan downward from the farthest offset so the nearest pending channel at/after base wins.
  always_comb begin
    base = (ARB_MODE != 0) ? '0 : rr_ptr;
    idx  = '0;
    win  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = PW'((int'(base) + i) % NUM_CH);
      if (pend[idx]) win = idx;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (win == PW'(k)) begin
        sel_addr  = ch_address[k*ADDR_W +: ADDR_W];
        sel_be    = ch_byte_enable[k*BE_W +: BE_W];
        sel_wdata = ch_write_data[k*DATA_W +: DATA_W];
        sel_wr    = ch_write[k];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_pend) state_nx = ISSUE;
      ISSUE:   if (mem_acknowledge || tmo_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr          <= '0;
      tmo_cnt         <= '0;
      err             <= 1'b0;
      grant_id        <= '0;
      mem_address     <= '0;
      mem_byte_enable <= '0;
      mem_write_data  <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      ch_read_data    <= '0;
      txn_count       <= '0;
    end else begin
      case (state)
        IDLE: if (any_pend) begin
          grant_id        <= 3'(win);
          rr_ptr          <= (win == PW'(NUM_CH - 1)) ? '0 : win + 1'b1;
          mem_address     <= sel_addr;
          mem_byte_enable <= sel_be;
          mem_write_data  <= sel_wdata;
          mem_write       <= sel_wr;
          mem_read        <= ~sel_wr;
          tmo_cnt         <= '0;
          err             <= 1'b0;
        end
        ISSUE: begin
          // An acknowledge on the final timeout cycle still counts as a normal completion.
          if (mem_acknowledge) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) ch_read_data <= mem_read_data;
          end else if (tmo_hit) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            ch_read_data <= '0;
            err          <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP:    txn_count <= txn_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign ch_acknowledge = (state == RESP) ? (NUM_CH'(1) << grant_id) : '0;
  assign ch_error       = (state == RESP && err) ? (NUM_CH'(1) << grant_id) : '0;

endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of requester channels, legal range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 128: data width; BE_W = DATA_W/8.
REQ-003 The block SHALL have parameter ADDR_W, default 26: address width.
REQ-004 The block SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1024: cycles to wait for mem_acknowledge; 0 disables the timeout.
REQ-006 The block SHALL have port clk, in, 1: single clock; one clock, all logic on its rising edge.
REQ-007 The block SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-008 The block SHALL have port ch_address, in, NUM_CH*ADDR_W: per-channel address, with channel k at slice [k*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port ch_byte_enable, in, NUM_CH*BE_W: per-channel byte enables.
REQ-010 The block SHALL have ports ch_read and ch_write, in, NUM_CH each: per-channel request strobes, held high until acknowledged.
REQ-011 The block SHALL have port ch_write_data, in, NUM_CH*DATA_W: per-channel write data.
REQ-012 The block SHALL have port ch_acknowledge, out, NUM_CH: one-cycle completion pulse to the granted channel.
REQ-013 The block SHALL have port ch_error, out, NUM_CH: one-cycle timeout flag, coincident with ch_acknowledge.
REQ-014 The block SHALL have port ch_read_data, out, DATA_W: shared registered read data, valid only in the ch_acknowledge cycle.
REQ-015 The block SHALL have ports mem_address (ADDR_W), mem_byte_enable (BE_W), mem_read (1), mem_write (1) and mem_write_data (DATA_W), out: registered downstream request.
REQ-016 The block SHALL have ports mem_acknowledge (1) and mem_read_data (DATA_W), in: downstream completion and read data.
REQ-017 The block SHALL have port grant_id, out, 3: index of the current or last granted channel.
REQ-018 The block SHALL have port busy, out, 1: high in states ISSUE and RESP.
REQ-019 The block SHALL have port txn_count, out, 16: count of completed transactions, wrapping modulo 2^16.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-021 In IDLE, a channel SHALL be pending when its ch_read or ch_write is high; if any channel is pending, the block SHALL select a winner and go to ISSUE on the next edge; otherwise it SHALL stay in IDLE.
REQ-022 In round-robin mode, the winner SHALL be the first pending channel at or after pointer rr_ptr, searching upward with wrap from NUM_CH-1 to 0.
REQ-023 When a grant is given to channel k, rr_ptr SHALL become (k+1) mod NUM_CH; rr_ptr SHALL NOT change when no grant is given.
REQ-024 In fixed-priority mode, the winner SHALL be the lowest-index pending channel, and rr_ptr SHALL be ignored.
REQ-025 On the IDLE-to-ISSUE edge, the block SHALL register the winner's address, byte enables and write data onto the mem_* ports, assert exactly one of mem_read or mem_write, and update grant_id.
REQ-026 If ch_read and ch_write are both high on the winning channel, the block SHALL treat the transaction as a write.
REQ-027 In ISSUE, the block SHALL hold all mem_* outputs stable until mem_acknowledge is sampled high.
REQ-028 When mem_acknowledge is sampled high in ISSUE, the block SHALL deassert mem_read and mem_write, capture mem_read_data into ch_read_data (reads only; write transactions leave ch_read_data unchanged), and go to RESP.
REQ-029 In RESP, the block SHALL pulse ch_acknowledge[grant_id] for exactly one cycle, increment txn_count, and return to IDLE on the next edge.
REQ-030 Latency SHALL be: request seen in IDLE at cycle N; mem strobe high from N+1; mem_acknowledge at cycle M; ch_acknowledge at M+1; earliest next grant evaluated at M+2.
REQ-031 A requester SHALL deassert its strobe within one cycle of ch_acknowledge; a strobe still high at M+2 SHALL count as a new request.
REQ-032 If TIMEOUT_CYC is nonzero and mem_acknowledge has not arrived after TIMEOUT_CYC cycles in ISSUE, the block SHALL drop mem_read and mem_write, load ch_read_data with zero, and go to RESP with ch_error[grant_id] pulsed alongside ch_acknowledge.
REQ-033 A mem_acknowledge arriving while the block is in IDLE or RESP SHALL be ignored.
REQ-034 Changes on a non-granted channel's inputs during ISSUE SHALL have no effect on the mem_* outputs.

Reset
REQ-035 While reset is high, all outputs, rr_ptr and the timeout counter SHALL be zero, and the FSM SHALL be in IDLE.
REQ-036 Reset asserted in the middle of a transaction SHALL abandon it: no ch_acknowledge is issued, and mem_read and mem_write drop immediately.

Verification
REQ-037 Single read: ch_read[2]=1 at address 0x00_1234; mem_acknowledge 3 cycles after mem_read with mem_read_data=0xA5..A5 -> ch_acknowledge[2] pulses 1 cycle later, ch_read_data=0xA5..A5, txn_count=1.
REQ-038 Round-robin: all 4 channels requesting continuously with a 1-cycle acknowledge -> grant order 0,1,2,3,0, ch_acknowledge pulses 4 cycles apart.
REQ-039 Fixed priority (ARB_MODE=1): channels 1 and 3 requesting -> channel 1 is served first; channel 3 is served only after channel 1 drops its request.
REQ-040 Timeout: TIMEOUT_CYC=8 and mem_acknowledge never asserted -> mem_write drops after 8 cycles, ch_error and ch_acknowledge pulse together, ch_read_data=0.
REQ-041 Reset mid-ISSUE: reset asserted 2 cycles after mem_read -> mem_read=0 asynchronously, no ch_acknowledge, grant_id=0, rr_ptr=0.
REQ-042 Read+write collision: ch_read[0]=ch_write[0]=1 -> mem_write=1 and mem_read=0; txn_count wraps from 0xFFFF to 0x0000.
